// File: rtl/rsa_run_sequencer.sv
// rsa_run_sequencer: holds enabled cores in reset, releases them together,
// and timestamps each core's done edge against a free-running run counter.
module rsa_run_sequencer #(
  parameter int NUM_CORES  = 4,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 2**20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_en,
  input  logic                       abort,
  input  logic                       ack,
  input  logic [NUM_CORES-1:0]       done,
  output logic [NUM_CORES-1:0]       core_rst,
  output logic [NUM_CORES-1:0]       selected,
  output logic                       busy,
  output logic [NUM_CORES-1:0]       finished,
  output logic [NUM_CORES*CNT_W-1:0] cycle_cnt,
  output logic                       irq,
  output logic                       timed_out
);

  localparam int HW = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RUN, S_DONE, S_TMO
  } state_t;

  state_t               state;
  logic [NUM_CORES-1:0] en_q;
  logic [NUM_CORES-1:0] done_q;
  logic [HW-1:0]        hold;
  logic [CNT_W-1:0]     run_cnt;
  logic [NUM_CORES-1:0] edges;
  logic [NUM_CORES-1:0] fin_nx;
  logic                 all_done;

  // A level already high on RUN entry never forms an edge, since done_q
  // tracks done in every state.
  always_comb begin
    edges    = done & ~done_q & en_q & ~finished;
    fin_nx   = finished | edges;
    all_done = ((fin_nx & en_q) == en_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      core_rst  <= '1;
      selected  <= '0;
      busy      <= 1'b0;
      finished  <= '0;
      cycle_cnt <= '0;
      irq       <= 1'b0;
      timed_out <= 1'b0;
      en_q      <= '0;
      done_q    <= '0;
      hold      <= '0;
      run_cnt   <= '0;
    end else begin
      done_q <= done;
      irq    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          core_rst <= '0;
          if (start && |core_en) begin
            en_q      <= core_en;
            finished  <= '0;
            cycle_cnt <= '0;
            hold      <= HW'(RST_CYCLES);
            core_rst  <= core_en;
            busy      <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (abort) begin
            core_rst <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (hold == HW'(1)) begin
            core_rst <= '0;
            selected <= en_q;
            run_cnt  <= '0;
            state    <= S_RUN;
          end else begin
            hold <= hold - HW'(1);
          end
        end
        S_RUN: begin
          if (abort) begin
            selected <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else begin
            run_cnt  <= run_cnt + CNT_W'(1);
            finished <= fin_nx;
            for (int i = 0; i < NUM_CORES; i++)
              if (edges[i])
                cycle_cnt[i*CNT_W +: CNT_W] <= run_cnt;
            if (all_done) begin
              selected <= '0;
              busy     <= 1'b0;
              irq      <= 1'b1;
              state    <= S_DONE;
            end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
              selected  <= '0;
              busy      <= 1'b0;
              irq       <= 1'b1;
              timed_out <= 1'b1;
              state     <= S_TMO;
            end
          end
        end
        S_DONE, S_TMO: begin
          if (ack || abort) begin
            timed_out <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_run_sequencer.sv
// Directed bench for rsa_run_sequencer: 4 cores, RST_CYCLES=2,
// TIMEOUT=100.
module tb_rsa_run_sequencer;

  localparam int N  = 4;
  localparam int CW = 32;

  logic          clk = 0;
  logic          rst = 0;
  logic          start = 0;
  logic [N-1:0]  core_en = '0;
  logic          abort = 0;
  logic          ack = 0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  core_rst;
  logic [N-1:0]  selected;
  logic          busy;
  logic [N-1:0]  finished;
  logic [N*CW-1:0] cycle_cnt;
  logic          irq;
  logic          timed_out;

  int total = 0;
  int bad = 0;
  int cyc;

  rsa_run_sequencer #(
    .NUM_CORES(N), .CNT_W(CW), .RST_CYCLES(2), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .core_en(core_en),
    .abort(abort), .ack(ack), .done(done), .core_rst(core_rst),
    .selected(selected), .busy(busy), .finished(finished),
    .cycle_cnt(cycle_cnt), .irq(irq), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] cc(input int i);
    return cycle_cnt[i*CW +: CW];
  endfunction

  // Start a run and leave the bench in RUN cycle 0.
  task automatic launch(input logic [N-1:0] en);
    core_en = en; start = 1;
    tick();
    start = 0;
    tick();
    tick();
    cyc = 0;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) begin tick(); cyc++; end
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    total++; if (core_rst !== 4'hF) begin bad++;
      $display("FAIL reset_core_rst got=%h exp=F", core_rst); end
    total++; if (selected !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_sel_busy got=%h/%b exp=0/0", selected, busy); end
    total++; if (finished !== 4'h0 || irq !== 1'b0 || timed_out !== 1'b0
                 || cycle_cnt !== '0) begin bad++;
      $display("FAIL reset_misc fin=%h irq=%b to=%b exp=0", finished, irq, timed_out); end
    rst = 1;
    tick();
    total++; if (core_rst !== 4'h0) begin bad++;
      $display("FAIL release_core_rst got=%h exp=0", core_rst); end
  endtask

  task automatic test_basic();
    core_en = 4'b0101; start = 1;
    tick();
    start = 0;
    total++; if (core_rst !== 4'b0101 || selected !== 4'h0 || busy !== 1'b1) begin bad++;
      $display("FAIL hold1 rst=%h sel=%h busy=%b exp=5/0/1", core_rst, selected, busy); end
    tick();
    total++; if (core_rst !== 4'b0101 || selected !== 4'h0) begin bad++;
      $display("FAIL hold2 rst=%h sel=%h exp=5/0", core_rst, selected); end
    tick();
    cyc = 0;
    total++; if (core_rst !== 4'h0 || selected !== 4'b0101) begin bad++;
      $display("FAIL run0 rst=%h sel=%h exp=0/5", core_rst, selected); end
    run_to(10);
    done[0] = 1;
    tick(); cyc++;
    total++; if (finished !== 4'b0001 || cc(0) !== 10 || irq !== 1'b0) begin bad++;
      $display("FAIL core0_edge fin=%h cc0=%0d irq=%b exp=1/10/0", finished, cc(0), irq); end
    run_to(25);
    done[2] = 1;
    tick(); cyc++;
    total++; if (irq !== 1'b1 || finished !== 4'b0101 || timed_out !== 1'b0) begin bad++;
      $display("FAIL done_irq irq=%b fin=%h to=%b exp=1/5/0", irq, finished, timed_out); end
    total++; if (cc(0) !== 10 || cc(2) !== 25 || cc(1) !== 0) begin bad++;
      $display("FAIL done_cnts cc0=%0d cc2=%0d cc1=%0d exp=10/25/0", cc(0), cc(2), cc(1)); end
    total++; if (selected !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL done_outs sel=%h busy=%b exp=0/0", selected, busy); end
    tick();
    total++; if (irq !== 1'b0) begin bad++;
      $display("FAIL irq_pulse got=%b exp=0", irq); end
    ack = 1; tick(); ack = 0; done = '0;
    tick();
    total++; if (cc(2) !== 25 || finished !== 4'b0101 || busy !== 1'b0) begin bad++;
      $display("FAIL after_ack cc2=%0d fin=%h busy=%b exp=25/5/0", cc(2), finished, busy); end
  endtask

  task automatic test_same_cycle();
    launch(4'b1011);
    total++; if (finished !== 4'h0 || cycle_cnt !== '0) begin bad++;
      $display("FAIL start_clear fin=%h exp=0", finished); end
    run_to(7);
    done[1] = 1; done[3] = 1;
    tick(); cyc++;
    total++; if (finished !== 4'b1010 || cc(1) !== 7 || cc(3) !== 7 || irq !== 1'b0) begin bad++;
      $display("FAIL same_cycle fin=%h cc1=%0d cc3=%0d irq=%b exp=A/7/7/0",
               finished, cc(1), cc(3), irq); end
    run_to(10); done[1] = 0;
    run_to(12); done[1] = 1;
    run_to(15); done[0] = 1;
    tick(); cyc++;
    total++; if (irq !== 1'b1 || cc(1) !== 7 || cc(0) !== 15 || finished !== 4'b1011) begin bad++;
      $display("FAIL retoggle irq=%b cc1=%0d cc0=%0d fin=%h exp=1/7/15/B",
               irq, cc(1), cc(0), finished); end
    ack = 1; tick(); ack = 0; done = '0;
    tick();
  endtask

  task automatic test_timeout();
    launch(4'b0011);
    run_to(3); done[0] = 1;
    run_to(99);
    total++; if (timed_out !== 1'b0 || irq !== 1'b0 || selected !== 4'b0011) begin bad++;
      $display("FAIL pre_timeout to=%b irq=%b sel=%h exp=0/0/3", timed_out, irq, selected); end
    tick(); cyc++;
    total++; if (timed_out !== 1'b1 || irq !== 1'b1 || selected !== 4'h0) begin bad++;
      $display("FAIL timeout to=%b irq=%b sel=%h exp=1/1/0", timed_out, irq, selected); end
    tick();
    total++; if (timed_out !== 1'b1 || irq !== 1'b0) begin bad++;
      $display("FAIL timeout_hold to=%b irq=%b exp=1/0", timed_out, irq); end
    ack = 1; tick(); ack = 0; done = '0;
    total++; if (timed_out !== 1'b0 || cc(0) !== 3 || finished !== 4'b0001) begin bad++;
      $display("FAIL timeout_ack to=%b cc0=%0d fin=%h exp=0/3/1", timed_out, cc(0), finished); end
  endtask

  task automatic test_abort();
    launch(4'b0100);
    run_to(5);
    abort = 1; tick(); abort = 0;
    total++; if (selected !== 4'h0 || busy !== 1'b0 || irq !== 1'b0 || core_rst !== 4'h0) begin bad++;
      $display("FAIL abort sel=%h busy=%b irq=%b rst=%h exp=0/0/0/0",
               selected, busy, irq, core_rst); end
    tick();
    total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL abort_noirq irq=%b busy=%b exp=0/0", irq, busy); end
    core_en = 4'h0; start = 1; tick(); start = 0;
    tick(); tick();
    total++; if (busy !== 1'b0 || core_rst !== 4'h0 || selected !== 4'h0) begin bad++;
      $display("FAIL zero_en busy=%b rst=%h sel=%h exp=0/0/0", busy, core_rst, selected); end
  endtask

  task automatic test_done_held();
    done[0] = 1;
    tick();
    launch(4'b0001);
    run_to(20); done[0] = 0;
    tick(); cyc++;
    total++; if (finished !== 4'h0 || busy !== 1'b1) begin bad++;
      $display("FAIL held_level fin=%h busy=%b exp=0/1", finished, busy); end
    run_to(40); done[0] = 1;
    tick(); cyc++;
    total++; if (cc(0) !== 40 || irq !== 1'b1 || finished !== 4'b0001) begin bad++;
      $display("FAIL held_edge cc0=%0d irq=%b fin=%h exp=40/1/1", cc(0), irq, finished); end
    ack = 1; tick(); ack = 0; done = '0;
    tick();
    launch(4'b0001);
    run_to(5);
    rst = 0; tick(); rst = 1;
    total++; if (core_rst !== 4'hF || selected !== 4'h0 || busy !== 1'b0 ||
                 finished !== 4'h0 || cycle_cnt !== '0 || irq !== 1'b0 ||
                 timed_out !== 1'b0) begin bad++;
      $display("FAIL mid_reset rst=%h sel=%h busy=%b fin=%h exp=F/0/0/0",
               core_rst, selected, busy, finished); end
    tick();
    total++; if (core_rst !== 4'h0 || busy !== 1'b0) begin bad++;
      $display("FAIL post_reset rst=%h busy=%b exp=0/0", core_rst, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_timeout();
    test_abort();
    test_done_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
